verificador_hash: RTL and testbench
===================================

# verificador_hash

- Sits directly downstream of the nonce generator.
- Captures each 24-bit nonce and forms a 16-byte message from it plus a 12-byte block payload.
- Runs a 32-round iterative 8-bit hash over the message, one round per clock, and reports the 24-bit digest.
- Flags the nonce as a winner when the digest's top byte is below the target. Its `listo` output drives the generator's `valid` input, providing backpressure.

## Interface
- `K1`, 8'h99, round constant for rounds 0–15
- `K2`, 8'hA1, round constant for rounds 16–31
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `nonce`  in  24  candidate nonce from the generator
- `nonce_valid`  in  1  `nonce` is valid this cycle
- `bloque`  in  96  block payload; byte 0 = `bloque[95:88]`; held stable by the system
- `objetivo`  in  8  target; sampled together with the nonce
- `listo`  out  1  block is idle and accepts a nonce this cycle
- `hash`  out  24  digest `{H0,H1,H2}`
- `hash_valid`  out  1  one-cycle pulse: `hash`, `encontrado` and `nonce_ok` are valid
- `encontrado`  out  1  `H0 < objetivo` for the reported nonce
- `nonce_ok`  out  24  nonce corresponding to the reported `hash`

## Operation
- **States:** `IDLE`, `RONDAS`, `PARADO`; the last exists only with the macro defined.
- **IDLE:** `listo=1`. On an edge with `nonce_valid=1`:
  - latch `nonce` and `objetivo`;
  - build `W[0..15]`: `W[0..11]` = `bloque` bytes MSB first; `W[12..14]` = `nonce[23:16]`, `nonce[15:8]`, `nonce[7:0]`; `W[15]` = 8'h80;
  - set `A=8'h01`, `B=8'h89`, `C=8'hFE`, round counter `i=0`;
  - go to `RONDAS`.
- **Schedule:** `W[j] = W[j-3] | (W[j-9] ^ W[j-14])` for j = 16..31. It may be precomputed at capture or generated on the fly; the results must be identical.
- **Per round i (RONDAS, one per edge):**
  - K = `K1` if i<16, else `K2`.
  - X = A^B if i<16, else A^B^C.
  - A←B^C.
  - B←{C[3:0],C[7:4]}.
  - C←(X+K+W[i]) mod 256.
  - i←i+1.
- **Finalisation, on the edge executing round 31:**
  - `H0=(8'h01+A') mod 256`, `H1=(8'h89+B') mod 256`, `H2=(8'hFE+C') mod 256`, using the post-round values.
  - Register `hash`, `nonce_ok`, `encontrado=(H0<objetivo_latched)`, `hash_valid=1`.
  - Next state `IDLE` (or `PARADO`, see Configuration).
- **Arithmetic:** all 8-bit, wrap-around. The comparison is unsigned and strict, so `objetivo=0` never finds a winner.
- **Backpressure:** `nonce_valid` while `listo=0` is ignored; nothing is queued.
- **Held outputs:** `hash`, `nonce_ok`, `encontrado` hold their last values until the next finalisation. `hash_valid` is a single-cycle pulse.
- **Reset:** any state → `IDLE`; an in-flight computation is discarded. Output values under reset:
  - `listo=1`
  - `hash=0`
  - `hash_valid=0`
  - `encontrado=0`
  - `nonce_ok=0`

## Timing
- Capture edge E0 (`listo=1`, `nonce_valid=1`): `listo` is low from after E0.
- Rounds execute on edges E1..E32.
- After E32: `hash_valid=1` for exactly one cycle, and `listo=1` again.
- Throughput: a new nonce captured on E33 at the earliest, i.e. one nonce per 33 cycles.
- Latency: 32 cycles from the capture edge to `hash_valid` high.
- `bloque` changes during `RONDAS` are undefined behaviour. `objetivo` changes after E0 have no effect on the current nonce.
- Reset asserted mid-`RONDAS`: outputs clear immediately (asynchronously); no `hash_valid` pulse for the aborted nonce.

## Configuration
- Macro: `VERIFICADOR_PARADA_EN`.
- **Defined:**
  - A finalisation with `encontrado=1` moves the FSM to `PARADO`.
  - In `PARADO`: `listo=0` forever, and `hash`, `nonce_ok`, `encontrado=1` are frozen; `hash_valid` still pulses once.
  - Only `reset` leaves `PARADO`.
- **Not defined:**
  - No `PARADO` state; the block always returns to `IDLE`.
  - `encontrado` is reported per nonce and the search continues indefinitely.

## Test plan
- **Reset values:** assert `reset` mid-round (e.g. at E10) → outputs immediately `listo=1`, `hash=0`, `hash_valid=0`, `encontrado=0`, `nonce_ok=0`; no `hash_valid` pulse for that nonce; the next nonce completes normally.
- **Latency:** `bloque`=96'h0, `nonce`=24'h000000, `objetivo`=8'h00 → `hash_valid` exactly 32 cycles after capture; `hash` equals the golden model; `encontrado=0`; `nonce_ok=0`.
- **Backpressure:** hold `nonce_valid=1` continuously with `nonce` incrementing every cycle from 24'h000001 → nonces captured only when `listo=1`, so the captured sequence is 1, 34, 67…; each `hash` matches the model for its `nonce_ok`.
- **Target compare:** sweep 256 nonces with `objetivo`=8'h40 → `encontrado==(hash[23:16]<8'h40)` on every `hash_valid`; with `objetivo`=8'h00, `encontrado` is never 1.
- **Halt (`VERIFICADOR_PARADA_EN` defined):** `objetivo`=8'h80, sweep nonces → after the first winner `listo` stays 0 for ≥100 cycles and `nonce_ok` is frozen at the winner; `reset` restores `listo=1`.
- **Halt (`VERIFICADOR_PARADA_EN` not defined):** `objetivo`=8'h80, sweep nonces → search continues past winners, with multiple `encontrado` pulses.

Source files
------------

// File: rtl/verificador_hash_if.sv
// verificador_hash_if
//   Groups the nonce-capture inputs and the digest-report outputs of
//   verificador_hash into one bundle.
//   master : the nonce generator side (drives nonce, nonce_valid, bloque,
//            objetivo; observes listo and the report signals)
//   slave  : the hash checker itself
//   Signals:
//     nonce[23:0]    candidate nonce
//     nonce_valid    nonce is valid this cycle
//     bloque[95:0]   block payload, byte 0 = bloque[95:88]
//     objetivo[7:0]  target, sampled with the nonce
//     listo          checker idle, accepts a nonce this cycle
//     hash[23:0]     digest {H0,H1,H2}
//     hash_valid     one-cycle pulse qualifying hash/encontrado/nonce_ok
//     encontrado     H0 < objetivo for the reported nonce
//     nonce_ok[23:0] nonce that produced the reported hash
interface verificador_hash_if;
  logic [23:0] nonce;
  logic        nonce_valid;
  logic [95:0] bloque;
  logic [7:0]  objetivo;
  logic        listo;
  logic [23:0] hash;
  logic        hash_valid;
  logic        encontrado;
  logic [23:0] nonce_ok;

  modport master (
    output nonce, nonce_valid, bloque, objetivo,
    input  listo, hash, hash_valid, encontrado, nonce_ok
  );

  modport slave (
    input  nonce, nonce_valid, bloque, objetivo,
    output listo, hash, hash_valid, encontrado, nonce_ok
  );
endinterface

// File: rtl/verificador_hash.sv
// verificador_hash
//   Captures a 24-bit nonce, builds a 16-byte message from the 12-byte block
//   payload plus the nonce and a pad byte, runs a 32-round 8-bit hash (one
//   round per clock) and reports a 24-bit digest. The nonce is a winner when
//   the top digest byte is strictly below the target sampled with it.
//   Ports:
//     clk    : single rising-edge clock
//     reset  : asynchronous, active-high reset
//     bus_if : verificador_hash_if.slave (nonce in, digest report out)
//   Optional feature macro: VERIFICADOR_PARADA_EN
//     defined   -> the first winner parks the FSM in PARADO (listo held low,
//                  report frozen) until reset
//     undefined -> the search continues after every nonce
module verificador_hash (
  input  logic              clk,
  input  logic              reset,
  verificador_hash_if.slave bus_if
);

  localparam logic [7:0] K1   = 8'h99;
  localparam logic [7:0] K2   = 8'hA1;
  localparam logic [7:0] IV_A = 8'h01;
  localparam logic [7:0] IV_B = 8'h89;
  localparam logic [7:0] IV_C = 8'hFE;
  localparam logic [7:0] PAD  = 8'h80;

`ifdef VERIFICADOR_PARADA_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RONDAS = 2'd1, PARADO = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RONDAS = 2'd1} state_t;
`endif

  state_t      state_q, state_d;
  logic [4:0]  i_q, i_d;
  logic [7:0]  a_q, a_d, b_q, b_d, c_q, c_d;
  // Sliding schedule window: w_q[k] holds W[i+k] for the current round i.
  logic [7:0]  w_q [16];
  logic [7:0]  w_d [16];
  logic [23:0] nonce_q, nonce_d;
  logic [7:0]  objetivo_q, objetivo_d;
  logic        listo_q, listo_d;
  logic [23:0] hash_q, hash_d;
  logic        hash_valid_q, hash_valid_d;
  logic        encontrado_q, encontrado_d;
  logic [23:0] nonce_ok_q, nonce_ok_d;

  logic [7:0]  k_s, x_s, a_next_s, b_next_s, c_next_s;
  logic [7:0]  h0_s, h1_s, h2_s, w_new_s;

  // Round datapath and digest of the post-round state.
  always_comb begin
    k_s      = i_q[4] ? K2 : K1;
    x_s      = i_q[4] ? (a_q ^ b_q ^ c_q) : (a_q ^ b_q);
    a_next_s = b_q ^ c_q;
    b_next_s = {c_q[3:0], c_q[7:4]};
    c_next_s = x_s + k_s + w_q[0];
    h0_s     = IV_A + a_next_s;
    h1_s     = IV_B + b_next_s;
    h2_s     = IV_C + c_next_s;
    // W[i+16] = W[i+13] | (W[i+7] ^ W[i+2]), generated as the window slides
    w_new_s  = w_q[13] | (w_q[7] ^ w_q[2]);
  end

  // Next-state and output logic of the capture/round FSM.
  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    for (int k = 0; k < 16; k++) begin
      w_d[k] = w_q[k];
    end
    nonce_d      = nonce_q;
    objetivo_d   = objetivo_q;
    hash_d       = hash_q;
    hash_valid_d = 1'b0;
    encontrado_d = encontrado_q;
    nonce_ok_d   = nonce_ok_q;

    case (state_q)
      IDLE: begin
        if (bus_if.nonce_valid) begin
          nonce_d    = bus_if.nonce;
          objetivo_d = bus_if.objetivo;
          for (int k = 0; k < 12; k++) begin
            w_d[k] = bus_if.bloque[95 - 8*k -: 8];
          end
          w_d[12]    = bus_if.nonce[23:16];
          w_d[13]    = bus_if.nonce[15:8];
          w_d[14]    = bus_if.nonce[7:0];
          w_d[15]    = PAD;
          a_d        = IV_A;
          b_d        = IV_B;
          c_d        = IV_C;
          i_d        = 5'd0;
          state_d    = RONDAS;
        end else begin
          state_d    = IDLE;
        end
      end
      RONDAS: begin
        a_d = a_next_s;
        b_d = b_next_s;
        c_d = c_next_s;
        i_d = i_q + 5'd1;
        for (int k = 0; k < 15; k++) begin
          w_d[k] = w_q[k + 1];
        end
        w_d[15] = w_new_s;
        if (i_q == 5'd31) begin
          hash_d       = {h0_s, h1_s, h2_s};
          nonce_ok_d   = nonce_q;
          encontrado_d = (h0_s < objetivo_q);
          hash_valid_d = 1'b1;
`ifdef VERIFICADOR_PARADA_EN
          if (h0_s < objetivo_q) begin
            state_d = PARADO;
          end else begin
            state_d = IDLE;
          end
`else
          state_d      = IDLE;
`endif
        end else begin
          state_d = RONDAS;
        end
      end
`ifdef VERIFICADOR_PARADA_EN
      PARADO: begin
        state_d = PARADO;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    listo_d = (state_d == IDLE);
  end

  // State and output registers; reset discards any in-flight nonce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      i_q          <= 5'd0;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      c_q          <= 8'h00;
      for (int k = 0; k < 16; k++) begin
        w_q[k] <= 8'h00;
      end
      nonce_q      <= 24'h000000;
      objetivo_q   <= 8'h00;
      listo_q      <= 1'b1;
      hash_q       <= 24'h000000;
      hash_valid_q <= 1'b0;
      encontrado_q <= 1'b0;
      nonce_ok_q   <= 24'h000000;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      for (int k = 0; k < 16; k++) begin
        w_q[k] <= w_d[k];
      end
      nonce_q      <= nonce_d;
      objetivo_q   <= objetivo_d;
      listo_q      <= listo_d;
      hash_q       <= hash_d;
      hash_valid_q <= hash_valid_d;
      encontrado_q <= encontrado_d;
      nonce_ok_q   <= nonce_ok_d;
    end
  end

  assign bus_if.listo      = listo_q;
  assign bus_if.hash       = hash_q;
  assign bus_if.hash_valid = hash_valid_q;
  assign bus_if.encontrado = encontrado_q;
  assign bus_if.nonce_ok   = nonce_ok_q;

endmodule

// File: tb/tb_verificador_hash.sv
// tb_verificador_hash
//   Directed bench for verificador_hash: reset values, a table of vectors,
//   reset in mid-computation, backpressure, target sweeps and the optional
//   halt-on-winner behaviour (VERIFICADOR_PARADA_EN).
module tb_verificador_hash;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  verificador_hash_if bus_if ();

  verificador_hash dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] bloque;
    logic [23:0] nonce;
    logic [7:0]  objetivo;
    logic [23:0] exp_hash;
    logic        exp_enc;
  } vector_t;

  vector_t tabla [6];

  // Reference digest: full 32-entry schedule built up front, then 32 rounds.
  function automatic logic [23:0] modelo(input logic [95:0] blq, input logic [23:0] n);
    logic [7:0] w [32];
    logic [7:0] a, b, c, x, k, na, nb, nc, h0, h1, h2;
    for (int j = 0; j < 12; j++) w[j] = blq[95 - 8*j -: 8];
    w[12] = n[23:16];
    w[13] = n[15:8];
    w[14] = n[7:0];
    w[15] = 8'h80;
    for (int j = 16; j < 32; j++) w[j] = w[j-3] | (w[j-9] ^ w[j-14]);
    a = 8'h01; b = 8'h89; c = 8'hFE;
    for (int r = 0; r < 32; r++) begin
      if (r < 16) begin
        k = 8'h99; x = a ^ b;
      end else begin
        k = 8'hA1; x = a ^ b ^ c;
      end
      na = b ^ c;
      nb = {c[3:0], c[7:4]};
      nc = x + k + w[r];
      a = na; b = nb; c = nc;
    end
    h0 = 8'h01 + a;
    h1 = 8'h89 + b;
    h2 = 8'hFE + c;
    return {h0, h1, h2};
  endfunction

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nombre, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulso_reset();
    reset = 1'b1;
    #1;
    chk("listo_tras_reset", 32'(bus_if.listo), 32'd1);
    #1;
    reset = 1'b0;
  endtask

  // One nonce from capture to report, checking latency and the report.
  task automatic procesar(input logic [95:0] blq, input logic [23:0] n, input logic [7:0] obj,
                          input logic [23:0] eh, input logic ee, input bit auto_reset,
                          output logic enc_o);
    int lat;
    bit hecho;
    lat = 0;
    while (!bus_if.listo && lat < 40) begin
      tick();
      lat++;
    end
    chk("listo_antes", 32'(bus_if.listo), 32'd1);
    bus_if.bloque      = blq;
    bus_if.nonce       = n;
    bus_if.objetivo    = obj;
    bus_if.nonce_valid = 1'b1;
    tick();
    bus_if.nonce_valid = 1'b0;
    bus_if.objetivo    = ~obj;
    bus_if.nonce       = ~n;
    chk("listo_ocupado", 32'(bus_if.listo), 32'd0);
    lat = 0;
    hecho = 1'b0;
    while (!hecho && lat < 40) begin
      tick();
      lat++;
      if (bus_if.hash_valid) hecho = 1'b1;
    end
    chk("latencia", 32'(lat), 32'd32);
    chk("hash", 32'(bus_if.hash), 32'(eh));
    chk("encontrado", 32'(bus_if.encontrado), 32'(ee));
    chk("nonce_ok", 32'(bus_if.nonce_ok), 32'(n));
    enc_o = bus_if.encontrado;
    tick();
    chk("pulso_unico", 32'(bus_if.hash_valid), 32'd0);
    chk("hash_retenido", 32'(bus_if.hash), 32'(eh));
`ifdef VERIFICADOR_PARADA_EN
    chk("listo_fin", 32'(bus_if.listo), 32'(!ee));
    if (ee && auto_reset) pulso_reset();
`else
    chk("listo_fin", 32'(bus_if.listo), 32'd1);
`endif
  endtask

  initial begin
    logic [95:0] blq;
    logic [23:0] n, eh, esperado;
    logic        ee, enc;
    int          vistos, esperados, ciclos, k, viol;
    bit          found;

    tabla[0] = '{96'h0, 24'h000000, 8'h00, 24'h0, 1'b0};
    tabla[1] = '{96'h0123_4567_89AB_CDEF_FEDC_BA98, 24'h000001, 8'h80, 24'h0, 1'b0};
    tabla[2] = '{{96{1'b1}}, 24'hFFFFFF, 8'hFF, 24'h0, 1'b0};
    tabla[3] = '{96'hDEAD_BEEF_CAFE_BABE_1234_5678, 24'h5A5A5A, 8'h40, 24'h0, 1'b0};
    tabla[4] = '{96'hDEAD_BEEF_CAFE_BABE_1234_5678, 24'hA5A5A5, 8'h01, 24'h0, 1'b0};
    tabla[5] = '{96'h0000_0000_0000_0000_0000_0001, 24'h800000, 8'hC0, 24'h0, 1'b0};
    for (int t = 0; t < 6; t++) begin
      tabla[t].exp_hash = modelo(tabla[t].bloque, tabla[t].nonce);
      tabla[t].exp_enc  = (tabla[t].exp_hash[23:16] < tabla[t].objetivo);
    end

    bus_if.nonce       = 24'h0;
    bus_if.nonce_valid = 1'b0;
    bus_if.bloque      = 96'h0;
    bus_if.objetivo    = 8'h00;
    reset              = 1'b1;
    tick();
    tick();
    chk("rst_listo", 32'(bus_if.listo), 32'd1);
    chk("rst_hash", 32'(bus_if.hash), 32'd0);
    chk("rst_hash_valid", 32'(bus_if.hash_valid), 32'd0);
    chk("rst_encontrado", 32'(bus_if.encontrado), 32'd0);
    chk("rst_nonce_ok", 32'(bus_if.nonce_ok), 32'd0);
    reset = 1'b0;
    tick();

    for (int t = 0; t < 6; t++) begin
      procesar(tabla[t].bloque, tabla[t].nonce, tabla[t].objetivo,
               tabla[t].exp_hash, tabla[t].exp_enc, 1'b1, enc);
    end

    // Reset after round 10 of a nonce: immediate clear, no report.
    bus_if.bloque      = 96'hDEAD_BEEF_CAFE_BABE_1234_5678;
    bus_if.nonce       = 24'hABCDEF;
    bus_if.objetivo    = 8'hFF;
    bus_if.nonce_valid = 1'b1;
    tick();
    bus_if.nonce_valid = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    #1;
    chk("mid_listo", 32'(bus_if.listo), 32'd1);
    chk("mid_hash", 32'(bus_if.hash), 32'd0);
    chk("mid_hash_valid", 32'(bus_if.hash_valid), 32'd0);
    chk("mid_encontrado", 32'(bus_if.encontrado), 32'd0);
    chk("mid_nonce_ok", 32'(bus_if.nonce_ok), 32'd0);
    #1;
    reset = 1'b0;
    viol = 0;
    repeat (40) begin
      tick();
      if (bus_if.hash_valid) viol++;
    end
    chk("mid_sin_pulso", 32'(viol), 32'd0);
    blq = 96'hDEAD_BEEF_CAFE_BABE_1234_5678;
    eh  = modelo(blq, 24'h123456);
    procesar(blq, 24'h123456, 8'hFF, eh, (eh[23:16] < 8'hFF), 1'b1, enc);

    // Backpressure: nonce_valid held high, nonce increments every cycle.
    bus_if.bloque      = blq;
    bus_if.objetivo    = 8'h00;
    bus_if.nonce       = 24'h000001;
    bus_if.nonce_valid = 1'b1;
    k = 0;
    ciclos = 0;
    while (k < 3 && ciclos < 120) begin
      tick();
      ciclos++;
      if (bus_if.hash_valid) begin
        esperado = 24'd1 + 24'(33 * k);
        chk("bp_nonce_ok", 32'(bus_if.nonce_ok), 32'(esperado));
        chk("bp_hash", 32'(bus_if.hash), 32'(modelo(blq, esperado)));
        k++;
      end
      if (k == 3) bus_if.nonce_valid = 1'b0;
      bus_if.nonce = bus_if.nonce + 24'd1;
    end
    bus_if.nonce_valid = 1'b0;
    chk("bp_resultados", 32'(k), 32'd3);
    tick();

    // Target 8'h40 over 256 nonces.
    for (int j = 0; j < 256; j++) begin
      n  = 24'h010000 + 24'(j);
      eh = modelo(blq, n);
      ee = (eh[23:16] < 8'h40);
      procesar(blq, n, 8'h40, eh, ee, 1'b1, enc);
    end

    // Target 0 never finds a winner.
    vistos = 0;
    for (int j = 0; j < 32; j++) begin
      n  = 24'h020000 + 24'(j);
      eh = modelo(blq, n);
      procesar(blq, n, 8'h00, eh, 1'b0, 1'b1, enc);
      vistos += int'(enc);
    end
    chk("objetivo_cero", 32'(vistos), 32'd0);

`ifdef VERIFICADOR_PARADA_EN
    // First winner parks the checker until reset.
    found = 1'b0;
    n = 24'h030000;
    while (!found && n < 24'h030040) begin
      eh = modelo(blq, n);
      ee = (eh[23:16] < 8'h80);
      procesar(blq, n, 8'h80, eh, ee, 1'b0, enc);
      if (ee) found = 1'b1;
      else n = n + 24'd1;
    end
    chk("parada_ganador", 32'(found), 32'd1);
    bus_if.nonce       = 24'h777777;
    bus_if.nonce_valid = 1'b1;
    viol = 0;
    repeat (100) begin
      tick();
      if (bus_if.listo !== 1'b0 || bus_if.nonce_ok !== n ||
          bus_if.hash_valid !== 1'b0 || bus_if.encontrado !== 1'b1) viol++;
    end
    bus_if.nonce_valid = 1'b0;
    chk("parada_congelado", 32'(viol), 32'd0);
    pulso_reset();
    tick();
    chk("parada_listo", 32'(bus_if.listo), 32'd1);
`else
    // Search continues past winners.
    vistos = 0;
    esperados = 0;
    for (int j = 0; j < 16; j++) begin
      n  = 24'h030000 + 24'(j);
      eh = modelo(blq, n);
      ee = (eh[23:16] < 8'h80);
      esperados += int'(ee);
      procesar(blq, n, 8'h80, eh, ee, 1'b1, enc);
      vistos += int'(enc);
    end
    chk("ganadores", 32'(vistos), 32'(esperados));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
